// File: rtl/accel_pkg.sv
// accel_pkg: shared definitions for the accelerometer frame packer.
//   HDR_BYTE_DEF - default frame start byte
//   tx_state_t   - byte-stream transmitter states
//   frame_len()  - bytes per frame for a given channel count
//   sext16()     - sign-extend a w-bit value (held in the low bits) to 16 bits
package accel_pkg;

  localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_SEQ,
    ST_DATA,
    ST_CSUM
  } tx_state_t;

  // header + seq + checksum + two bytes per channel
  function automatic int frame_len(input int num_ch);
    return 3 + 2 * num_ch;
  endfunction

  // Shift the sign bit up to bit 15 and arithmetic-shift back down.
  function automatic logic [15:0] sext16(input logic [15:0] v, input int w);
    logic signed [15:0] t;
    t = $signed(v << (16 - w));
    return 16'(t >>> (16 - w));
  endfunction

endpackage

// File: rtl/accel_avg_accum.sv
// accel_avg_accum: one channel of the box-car averager.
//   clk_i       system clock
//   rst_i       synchronous active-high reset
//   strobe_i    sample_i valid this cycle
//   clear_i     this strobe closes the window; accumulator restarts at zero
//   shift_en_i  window is averaged (shift by AVG_LOG2) rather than passed through
//   sample_i    two's complement sample
//   result_o    window result including the current sample, sign-extended to 16 bits
module accel_avg_accum
  import accel_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int AVG_LOG2 = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                strobe_i,
  input  logic                clear_i,
  input  logic                shift_en_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  output logic [15:0]         result_o
);

  localparam int ACC_W = SAMPLE_W + AVG_LOG2;

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    sum      = acc_q + ACC_W'($signed(sample_i));
    // >>> on a signed value floors toward -inf, which is the wanted rounding
    shifted  = shift_en_i ? (sum >>> AVG_LOG2) : sum;
    // after the shift the mean always fits back into SAMPLE_W bits
    result_o = sext16(16'(shifted[SAMPLE_W-1:0]), SAMPLE_W);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else if (strobe_i) begin
      acc_q <= clear_i ? '0 : sum;
    end
  end

endmodule

// File: rtl/accel_frame_packer.sv
// accel_frame_packer: averages NUM_CH sample channels and emits framed bytes.
//   Clk_i / Reset_i     clock, synchronous active-high reset
//   Data_Available_i    1-cycle strobe, Sample_i valid
//   Sample_i            channel k at [k*SAMPLE_W +: SAMPLE_W]
//   Avg_En_i            average 2^AVG_LOG2 strobes per frame (sampled at window start)
//   Byte_o/Byte_Valid_o/Byte_Ready_i   byte stream handshake to the UART
//   Frame_Done_o        pulse after the checksum byte is accepted
//   Overflow_o          pulse when a completed frame is dropped
//   Drop_Count_o        saturating count of dropped frames
//   Busy_o              frame in flight or pending
// Frame: HDR, seq, ch0 hi, ch0 lo, ..., csum (XOR of seq and data bytes).
module accel_frame_packer
  import accel_pkg::*;
#(
  parameter int         SAMPLE_W = 16,
  parameter int         NUM_CH   = 3,
  parameter int         AVG_LOG2 = 2,
  parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEF
) (
  input  logic                       Clk_i,
  input  logic                       Reset_i,
  input  logic                       Data_Available_i,
  input  logic [NUM_CH*SAMPLE_W-1:0] Sample_i,
  input  logic                       Avg_En_i,
  output logic [7:0]                 Byte_o,
  output logic                       Byte_Valid_o,
  input  logic                       Byte_Ready_i,
  output logic                       Frame_Done_o,
  output logic                       Overflow_o,
  output logic [7:0]                 Drop_Count_o,
  output logic                       Busy_o
);

  localparam int CNT_W     = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int FW        = NUM_CH * 16;
  localparam int DATA_LAST = frame_len(NUM_CH) - 4;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);

  // ---------------- window control ----------------
  logic [CNT_W-1:0] win_cnt_q;
  logic             avg_mode_q;
  logic             eff_mode;
  logic             win_done;

  // the mode latched on the first strobe of a window holds for the whole window
  assign eff_mode = (win_cnt_q == '0) ? Avg_En_i : avg_mode_q;
  assign win_done = Data_Available_i &&
                    (!eff_mode || (AVG_LOG2 == 0) || (win_cnt_q == LAST_CNT));

  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      win_cnt_q  <= '0;
      avg_mode_q <= 1'b0;
    end else if (Data_Available_i) begin
      avg_mode_q <= eff_mode;
      win_cnt_q  <= win_done ? '0 : win_cnt_q + 1'b1;
    end
  end

  // ---------------- per-channel accumulators ----------------
  logic [15:0]   ch_res [NUM_CH];
  logic [FW-1:0] res_flat;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      accel_avg_accum #(
        .SAMPLE_W(SAMPLE_W),
        .AVG_LOG2(AVG_LOG2)
      ) u_acc (
        .clk_i     (Clk_i),
        .rst_i     (Reset_i),
        .strobe_i  (Data_Available_i),
        .clear_i   (win_done),
        .shift_en_i(eff_mode),
        .sample_i  (Sample_i[gi*SAMPLE_W +: SAMPLE_W]),
        .result_o  (ch_res[gi])
      );
      // ch0 sits at the top so the frame can be shifted out MSB-first
      assign res_flat[(NUM_CH-1-gi)*16 +: 16] = ch_res[gi];
    end
  endgenerate

  // ---------------- pending buffer ----------------
  tx_state_t     state_q;
  logic          pend_q;
  logic [FW-1:0] pend_data_q;
  logic [7:0]    pend_seq_q;
  logic [7:0]    pend_csum_q;
  logic [7:0]    seq_ctr_q;
  logic          ovf_q;
  logic [7:0]    drop_q;
  logic          load;
  logic          pend_free;
  logic [7:0]    new_csum;

  // transmitter takes the pending frame from IDLE or straight out of CSUM
  assign load      = pend_q && ((state_q == ST_IDLE) ||
                                ((state_q == ST_CSUM) && Byte_Ready_i));
  assign pend_free = !pend_q || load;

  always_comb begin
    new_csum = seq_ctr_q;
    for (int k = 0; k < 2 * NUM_CH; k++) begin
      new_csum = new_csum ^ res_flat[k*8 +: 8];
    end
  end

  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      pend_seq_q  <= '0;
      pend_csum_q <= '0;
      seq_ctr_q   <= '0;
      ovf_q       <= 1'b0;
      drop_q      <= '0;
    end else begin
      ovf_q <= 1'b0;
      if (load) begin
        pend_q <= 1'b0;
      end
      if (win_done) begin
        if (pend_free) begin
          pend_q      <= 1'b1;
          pend_data_q <= res_flat;
          pend_seq_q  <= seq_ctr_q;
          pend_csum_q <= new_csum;
          seq_ctr_q   <= seq_ctr_q + 8'd1;
        end else begin
          ovf_q <= 1'b1;
          if (drop_q != 8'hFF) begin
            drop_q <= drop_q + 8'd1;
          end
        end
      end
    end
  end

  // ---------------- transmitter ----------------
  logic [FW-1:0] frame_q;
  logic [7:0]    frame_seq_q;
  logic [7:0]    frame_csum_q;
  logic [3:0]    idx_q;
  logic [7:0]    byte_q;
  logic          valid_q;
  logic          done_q;

  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      state_q      <= ST_IDLE;
      frame_q      <= '0;
      frame_seq_q  <= '0;
      frame_csum_q <= '0;
      idx_q        <= '0;
      byte_q       <= '0;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            state_q      <= ST_HDR;
            frame_q      <= pend_data_q;
            frame_seq_q  <= pend_seq_q;
            frame_csum_q <= pend_csum_q;
            byte_q       <= HDR_BYTE;
            valid_q      <= 1'b1;
          end
        end
        ST_HDR: begin
          if (Byte_Ready_i) begin
            state_q <= ST_SEQ;
            byte_q  <= frame_seq_q;
          end
        end
        ST_SEQ: begin
          if (Byte_Ready_i) begin
            state_q <= ST_DATA;
            idx_q   <= '0;
            byte_q  <= frame_q[FW-1 -: 8];
            frame_q <= {frame_q[FW-9:0], 8'h00};
          end
        end
        ST_DATA: begin
          if (Byte_Ready_i) begin
            if (idx_q == 4'(DATA_LAST)) begin
              state_q <= ST_CSUM;
              byte_q  <= frame_csum_q;
            end else begin
              idx_q   <= idx_q + 4'd1;
              byte_q  <= frame_q[FW-1 -: 8];
              frame_q <= {frame_q[FW-9:0], 8'h00};
            end
          end
        end
        ST_CSUM: begin
          if (Byte_Ready_i) begin
            done_q <= 1'b1;
            if (load) begin
              state_q      <= ST_HDR;
              frame_q      <= pend_data_q;
              frame_seq_q  <= pend_seq_q;
              frame_csum_q <= pend_csum_q;
              byte_q       <= HDR_BYTE;
            end else begin
              state_q <= ST_IDLE;
              byte_q  <= '0;
              valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          byte_q  <= '0;
        end
      endcase
    end
  end

  assign Byte_o       = byte_q;
  assign Byte_Valid_o = valid_q;
  assign Frame_Done_o = done_q;
  assign Overflow_o   = ovf_q;
  assign Drop_Count_o = drop_q;
  assign Busy_o       = (state_q != ST_IDLE) | pend_q;

endmodule
